sccb_slave_regs: RTL and testbench
==================================

# sccb_slave_regs

SCCB responder (camera-side emulator) with a 256×8 register file, answering the team's SCCB master on SIOC/SIOD. It oversamples the bus on the system clock, detects start/stop, matches the 7-bit device ID, acknowledges bytes, and stores written data or returns read data. It sits in simulation benches and FPGA loopback builds in place of the OV-series camera, and exposes a local host port and write strobes to the surrounding design.

## Interface
- DEV_ID, 8'h42, write ID; read ID is DEV_ID|1 (8'h43); bit0 of the received byte selects R/W.
- HOLD_CYC, 16, CLK cycles after a detected SIOC falling edge before SIOD drive changes; range 1–255.
- CLK  in  1  system clock (100 MHz nominal, ≥16× SIOC).
- RESET  in  1  asynchronous, active-high reset.
- SIOC  in  1  SCCB clock from master.
- SIOD  inout  1  SCCB data; driven only to 0 (open-drain style), otherwise 1'bz.
- HOST_ADDR  in  8  local read address.
- HOST_DATA  out  8  register file content at HOST_ADDR, combinational.
- WR_STB  out  1  one-CLK pulse per register written over SCCB.
- WR_ADDR  out  8  address of last SCCB write.
- WR_DATA  out  8  data of last SCCB write.
- RD_STB  out  1  one-CLK pulse per byte loaded for SCCB read.
- BUSY  out  1  high from start condition to stop condition.

## Operation
- SIOC and SIOD (input) pass through 2-flop synchronizers; edges detected on synced values. Z/pull-up on SIOD reads as 1.
- Start: synced SIOD 1→0 while synced SIOC high. Stop: SIOD 0→1 while SIOC high. Both override any state.
- Data bits sampled on SIOC rising edge, MSB first; drive changes happen HOLD_CYC after SIOC falling edge.
- States: IDLE, ID, ID_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- IDLE: SIOD released; start → ID, bit counter = 0.
- ID: shift 8 bits. Upper 7 bits ≠ DEV_ID[7:1] → WAIT_STOP (no ACK). Match → ID_ACK; R/W latched.
- ID_ACK: drive 0 for the 9th bit, release after its falling edge. Write → ADDR; read → RDATA with byte = regs[sub_addr], RD_STB pulsed.
- ADDR: shift 8 bits into sub_addr → ADDR_ACK (drive 0) → WDATA.
- WDATA: shift 8 bits; on 8th rising edge regs[sub_addr] ← byte, WR_STB/WR_ADDR/WR_DATA updated → WDATA_ACK (drive 0) → WDATA for further bytes (see Configuration).
- RDATA: drive bit7..bit0 (drive 0 for a 0 bit, release for a 1), release after 8th bit → RDATA_ACK; sample master 9th bit: 1 (NA) → WAIT_STOP; 0 → RDATA with next byte.
- WAIT_STOP: SIOD released; waits for stop or start.
- sub_addr persists across stop, so write-ID+addr, stop, start, read-ID reads the addressed register. Repeated start behaves identically.
- Register file reset value: all 0x00.

## Timing
- Reset: SIOD released, state IDLE, sub_addr 0, WR_STB 0, RD_STB 0, WR_ADDR 0, WR_DATA 0, BUSY 0, regs 0x00. Reset mid-transfer releases SIOD immediately (async).
- Detection latency: 2 sync + 1 edge = 3 CLK after bus transition.
- WR_STB asserted 3–4 CLK after SIOC rising edge of data bit0; HOST_DATA reflects new value next CLK.
- ACK drive asserted HOLD_CYC after the 8th falling edge, released HOLD_CYC after the 9th falling edge.
- Simultaneous SIOC and SIOD edges in one synced sample: SIOC edge processed, no start/stop.
- Start during any drive phase: SIOD released the same CLK, state → ID.

## Configuration
- SCCB_SLV_AUTOINC_EN defined: sub_addr increments after each written byte and each read byte loaded after the first; 8'hFF wraps to 8'h00.
- Undefined: sub_addr never changes within a transaction; extra written bytes overwrite the same register (still ACKed); extra read bytes repeat the same value.

## Test plan
- Write 0x42, addr 0x12, data 0x80, stop → three ACKs low, WR_STB once, WR_ADDR=0x12, WR_DATA=0x80, HOST_DATA@0x12=0x80, BUSY low after stop.
- Read: write 0x42/addr 0x12, stop, start, 0x43, master NA → SIOD bits 1000_0000, RD_STB once, WAIT_STOP then IDLE.
- ID 0x60 → no ACK (SIOD sampled 1 at 9th bit), no WR_STB, regs unchanged.
- With SCCB_SLV_AUTOINC_EN: write addr 0xFF, data 0xAA, 0x55 → regs[0xFF]=0xAA, regs[0x00]=0x55; without: regs[0xFF]=0x55.
- Start asserted mid-WDATA at bit 4 → partial byte discarded, no WR_STB, next ID parsed correctly.
- RESET pulsed while driving read bit 0 → SIOD high-Z within the reset cycle, all outputs at reset values, regs 0x00.

Source files
------------

// File: rtl/sccb_slave_regs_if.sv
// rtl/sccb_slave_regs_if.sv - SCCB bus bundle: clock, resolved data line and slave pull-down enable
// siod_in is the wired-AND of all open-drain drivers, pull-up included.
interface sccb_slave_regs_if;
    logic sioc;
    logic siod_in;
    logic siod_oe;

    modport master (output sioc, output siod_in, input siod_oe);
    modport slave  (input sioc, input siod_in, output siod_oe);
endinterface

// File: rtl/sccb_slave_regs.sv
// rtl/sccb_slave_regs.sv - SCCB responder with a 256x8 register file and local host read port
// Define SCCB_SLV_AUTOINC_EN to auto-increment the sub-address on multi-byte transfers.
module sccb_slave_regs #(
    parameter logic [7:0]  DEV_ID   = 8'h42,
    parameter int unsigned HOLD_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    sccb_slave_regs_if.slave bus,
    input  logic [7:0]       host_addr_i,
    output logic [7:0]       host_data_o,
    output logic             wr_stb_o,
    output logic [7:0]       wr_addr_o,
    output logic [7:0]       wr_data_o,
    output logic             rd_stb_o,
    output logic             busy_o
);
    typedef enum logic [3:0] {
        S_IDLE, S_ID, S_ID_ACK, S_ADDR, S_ADDR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT_STOP
    } state_t;

    localparam logic [7:0] HOLD_LD = 8'(HOLD_CYC);

    state_t     state_q;
    logic [1:0] sioc_sync_q, siod_sync_q;
    logic       sioc_prev_q, siod_prev_q;
    logic [2:0] cnt_q;
    logic [6:0] shift_q;
    logic [7:0] sub_addr_q, rbyte_q, hold_q;
    logic       rw_q, oe_q, wr_stb_q, rd_stb_q, busy_q;
    logic [7:0] wr_addr_q, wr_data_q;
    logic [7:0] regs_q [256];

    logic       sioc_s, siod_s, sioc_rise, sioc_fall, start_det, stop_det, drive_d;
    logic [7:0] byte_d, next_addr_d;

    assign sioc_s    = sioc_sync_q[1];
    assign siod_s    = siod_sync_q[1];
    assign sioc_rise = sioc_s & ~sioc_prev_q;
    assign sioc_fall = ~sioc_s & sioc_prev_q;
    // SIOC must be steadily high across the sample, so a coincident SIOC edge wins.
    assign start_det = sioc_s & sioc_prev_q & siod_prev_q & ~siod_s;
    assign stop_det  = sioc_s & sioc_prev_q & ~siod_prev_q & siod_s;
    assign byte_d    = {shift_q, siod_s};

`ifdef SCCB_SLV_AUTOINC_EN
    assign next_addr_d = sub_addr_q + 8'd1;
`else
    assign next_addr_d = sub_addr_q;
`endif

    // Line level to present once the hold time after a SIOC fall has elapsed.
    always_comb begin
        drive_d = 1'b0;
        case (state_q)
            S_ID_ACK, S_ADDR_ACK, S_WDATA_ACK: drive_d = 1'b1;
            S_RDATA:                           drive_d = ~rbyte_q[3'd7 - cnt_q];
            default:                           drive_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sioc_sync_q <= 2'b11;
            siod_sync_q <= 2'b11;
            sioc_prev_q <= 1'b1;
            siod_prev_q <= 1'b1;
            cnt_q       <= '0;
            shift_q     <= '0;
            sub_addr_q  <= '0;
            rbyte_q     <= '0;
            hold_q      <= '0;
            rw_q        <= 1'b0;
            oe_q        <= 1'b0;
            wr_stb_q    <= 1'b0;
            rd_stb_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            for (int i = 0; i < 256; i++) regs_q[i] <= '0;
        end else begin
            sioc_sync_q <= {sioc_sync_q[0], bus.sioc};
            siod_sync_q <= {siod_sync_q[0], bus.siod_in};
            sioc_prev_q <= sioc_s;
            siod_prev_q <= siod_s;
            wr_stb_q    <= 1'b0;
            rd_stb_q    <= 1'b0;
            if (start_det) begin
                state_q <= S_ID;
                cnt_q   <= '0;
                oe_q    <= 1'b0;
                hold_q  <= '0;
                busy_q  <= 1'b1;
            end else if (stop_det) begin
                state_q <= S_IDLE;
                oe_q    <= 1'b0;
                hold_q  <= '0;
                busy_q  <= 1'b0;
            end else begin
                if (sioc_fall) begin
                    hold_q <= HOLD_LD;
                end else if (hold_q != 8'd0) begin
                    hold_q <= hold_q - 8'd1;
                    if (hold_q == 8'd1) oe_q <= drive_d;
                end
                if (sioc_rise) begin
                    case (state_q)
                        S_ID: begin
                            shift_q <= byte_d[6:0];
                            cnt_q   <= cnt_q + 3'd1;
                            if (cnt_q == 3'd7) begin
                                rw_q    <= byte_d[0];
                                state_q <= (byte_d[7:1] == DEV_ID[7:1]) ? S_ID_ACK : S_WAIT_STOP;
                            end
                        end
                        S_ID_ACK: begin
                            if (rw_q) begin
                                state_q  <= S_RDATA;
                                rbyte_q  <= regs_q[sub_addr_q];
                                rd_stb_q <= 1'b1;
                            end else begin
                                state_q <= S_ADDR;
                            end
                        end
                        S_ADDR: begin
                            shift_q <= byte_d[6:0];
                            cnt_q   <= cnt_q + 3'd1;
                            if (cnt_q == 3'd7) begin
                                sub_addr_q <= byte_d;
                                state_q    <= S_ADDR_ACK;
                            end
                        end
                        S_ADDR_ACK, S_WDATA_ACK: state_q <= S_WDATA;
                        S_WDATA: begin
                            shift_q <= byte_d[6:0];
                            cnt_q   <= cnt_q + 3'd1;
                            if (cnt_q == 3'd7) begin
                                regs_q[sub_addr_q] <= byte_d;
                                wr_stb_q   <= 1'b1;
                                wr_addr_q  <= sub_addr_q;
                                wr_data_q  <= byte_d;
                                sub_addr_q <= next_addr_d;
                                state_q    <= S_WDATA_ACK;
                            end
                        end
                        S_RDATA: begin
                            cnt_q <= cnt_q + 3'd1;
                            if (cnt_q == 3'd7) state_q <= S_RDATA_ACK;
                        end
                        S_RDATA_ACK: begin
                            if (siod_s) begin
                                state_q <= S_WAIT_STOP;
                            end else begin
                                state_q    <= S_RDATA;
                                rbyte_q    <= regs_q[next_addr_d];
                                sub_addr_q <= next_addr_d;
                                rd_stb_q   <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.siod_oe = oe_q;
    assign host_data_o = regs_q[host_addr_i];
    assign wr_stb_o    = wr_stb_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign rd_stb_o    = rd_stb_q;
    assign busy_o      = busy_q;
endmodule

// File: tb/tb_sccb_slave_regs.sv
// tb/tb_sccb_slave_regs.sv - bit-banged SCCB master against a register-array model of the responder
`timescale 1ns/1ps
module tb_sccb_slave_regs;
    localparam int T = 24;
`ifdef SCCB_SLV_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sccb_slave_regs_if bus();
    logic       master_low = 1'b0;
    logic [7:0] host_addr = 8'h00;
    logic [7:0] host_fix = 8'h00;
    logic       host_rand = 1'b1;
    logic [7:0] host_data, wr_addr, wr_data;
    logic       wr_stb, rd_stb, busy;

    assign bus.siod_in = ~(master_low | bus.siod_oe);

    sccb_slave_regs dut (
        .clk(clk), .rst(rst), .bus(bus),
        .host_addr_i(host_addr), .host_data_o(host_data),
        .wr_stb_o(wr_stb), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
        .rd_stb_o(rd_stb), .busy_o(busy)
    );

    int checks = 0, errors = 0;
    logic [7:0] m_regs [256];
    logic [7:0] m_sub = 8'h00, m_wa = 8'h00, m_wd = 8'h00;
    int m_wr = 0, m_rd = 0, d_wr = 0, d_rd = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 40) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1 host_addr = host_rand ? 8'($urandom) : host_fix;
    end

    // Strobe counting always; idle-bus state checked whenever the bus is quiet.
    initial forever begin
        @(negedge clk);
        if (wr_stb) d_wr++;
        if (rd_stb) d_rd++;
        if (chk_en) begin
            chk("host_data", host_data, m_regs[host_addr]);
            chk("idle_busy", busy, 0);
            chk("idle_siod_oe", bus.siod_oe, 0);
            chk("wr_addr", wr_addr, m_wa);
            chk("wr_data", wr_data, m_wd);
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic bus_start();
        chk_en = 1'b0;
        master_low = 1'b0; wclk(T);
        bus.sioc = 1'b1;   wclk(T);
        master_low = 1'b1; wclk(T);
        bus.sioc = 1'b0;   wclk(4);
    endtask

    task automatic bus_stop();
        master_low = 1'b1; wclk(T - 4);
        bus.sioc = 1'b1;   wclk(T);
        master_low = 1'b0; wclk(T + 8);
        chk_en = 1'b1;
    endtask

    task automatic bus_bit(input logic b, output logic s);
        master_low = ~b; wclk(T - 4);
        bus.sioc = 1'b1; wclk(T / 2);
        s = bus.siod_in; wclk(T / 2);
        bus.sioc = 1'b0; wclk(4);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] v);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            v[i] = s;
        end
        bus_bit(nack, s);
    endtask

    task automatic do_write(input logic [7:0] a, input int n, input logic [31:0] dw, input bit with_stop);
        logic ack;
        logic [7:0] b;
        bus_start();
        send_byte(8'h42, ack); chk("wr_id_ack", ack, 0);
        chk("busy_mid", busy, 1);
        send_byte(a, ack);     chk("wr_addr_ack", ack, 0);
        m_sub = a;
        for (int k = 0; k < n; k++) begin
            b = dw[8*k +: 8];
            send_byte(b, ack); chk("wr_data_ack", ack, 0);
            m_regs[m_sub] = b; m_wa = m_sub; m_wd = b; m_wr++;
            if (AUTOINC) m_sub = m_sub + 8'd1;
        end
        if (with_stop) bus_stop();
        chk("wr_count", d_wr, m_wr);
    endtask

    task automatic do_read(input int n, output logic [31:0] got);
        logic ack;
        logic [7:0] v;
        got = '0;
        bus_start();
        send_byte(8'h43, ack); chk("rd_id_ack", ack, 0);
        for (int k = 0; k < n; k++) begin
            if (k > 0 && AUTOINC) m_sub = m_sub + 8'd1;
            m_rd++;
            recv_byte(k == n - 1, v);
            chk("rd_byte", v, m_regs[m_sub]);
            got[8*k +: 8] = v;
        end
        bus_stop();
        chk("rd_count", d_rd, m_rd);
    endtask

    task automatic bad_id(input logic [7:0] id);
        logic ack;
        bus_start();
        send_byte(id, ack);           chk("bad_id_nack", ack, 1);
        send_byte(8'($urandom), ack); chk("bad_id_follow_nack", ack, 1);
        bus_stop();
        chk("bad_id_wr_count", d_wr, m_wr);
    endtask

    task automatic host_peek(input logic [7:0] a, input logic [7:0] exp, input string name);
        host_rand = 1'b0; host_fix = a; wclk(3);
        chk(name, host_data, exp);
        host_rand = 1'b1;
    endtask

    initial begin
        logic [31:0] got;
        logic ack, s;
        logic [7:0] id;
        for (int i = 0; i < 256; i++) m_regs[i] = 8'h00;
        bus.sioc = 1'b1;
        wclk(4);
        chk("rst_siod_oe", bus.siod_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_stb", wr_stb, 0);
        chk("rst_rd_stb", rd_stb, 0);
        @(negedge clk); rst = 1'b0;
        wclk(4); chk_en = 1'b1; wclk(20);

        do_write(8'h12, 1, 32'h80, 1'b1);
        chk("t1_wr_addr", wr_addr, 8'h12);
        chk("t1_wr_data", wr_data, 8'h80);
        chk("t1_wr_stb_once", d_wr, 1);
        host_peek(8'h12, 8'h80, "t1_host_12");

        do_write(8'h12, 0, 32'h0, 1'b1);
        do_read(1, got);
        chk("t2_read_val", got[7:0], 8'h80);
        chk("t2_rd_stb_once", d_rd, 1);

        bad_id(8'h60);
        host_peek(8'h12, 8'h80, "t3_regs_unchanged");

        do_write(8'hFF, 2, 32'h55AA, 1'b1);
        host_peek(8'hFF, AUTOINC ? 8'hAA : 8'h55, "t4_reg_ff");
        host_peek(8'h00, AUTOINC ? 8'h55 : 8'h00, "t4_reg_00");

        // Start condition after four data bits: the partial byte must be dropped.
        bus_start();
        send_byte(8'h42, ack); chk("t5_id_ack", ack, 0);
        send_byte(8'h30, ack); chk("t5_addr_ack", ack, 0);
        m_sub = 8'h30;
        for (int i = 0; i < 4; i++) bus_bit(i[0], s);
        do_write(8'h31, 1, 32'hC3, 1'b1);
        host_peek(8'h30, m_regs[8'h30], "t5_reg_30_kept");
        host_peek(8'h31, 8'hC3, "t5_reg_31");

        for (int it = 0; it < 12; it++) begin
            case ($urandom_range(0, 3))
                0, 1: do_write(8'($urandom), $urandom_range(1, 3), $urandom, 1'b1);
                2: begin
                    do_write(8'($urandom), 0, 32'h0, 1'($urandom));
                    do_read($urandom_range(1, 3), got);
                end
                default: begin
                    do begin id = 8'($urandom); end while (id[7:1] == 7'h21);
                    bad_id(id);
                end
            endcase
        end

        // Reset while the responder pulls SIOD low for read bit 0 of 0x80.
        do_write(8'h5A, 1, 32'h80, 1'b1);
        bus_start();
        send_byte(8'h43, ack); chk("t6_id_ack", ack, 0);
        for (int i = 0; i < 7; i++) bus_bit(1'b1, s);
        master_low = 1'b0; wclk(T - 4);
        bus.sioc = 1'b1;   wclk(T / 2);
        chk("t6_drive_bit0", bus.siod_oe, 1);
        #2 rst = 1'b1;
        #1 chk("t6_rst_release", bus.siod_oe, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_wr_addr", wr_addr, 0);
        chk("t6_rst_wr_data", wr_data, 0);
        wclk(3);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 256; i++) m_regs[i] = 8'h00;
        m_sub = 8'h00; m_wa = 8'h00; m_wd = 8'h00;
        wclk(4);
        chk_en = 1'b1;
        host_peek(8'h5A, 8'h00, "t6_reg_cleared");
        wclk(100);

        chk_en = 1'b0;
        wclk(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
